// File: rtl/if_id_hazard_ctrl.sv
// Hazard and sequencing controller for the 8-bit in-order pipeline.
// Resolves load-use hazards, taken jumps (JumpPC) and data-memory waits by
// driving PC enable, IF/ID enable/flush and ID/EX bubble insertion.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   ID_rs1/ID_rs2     - source registers of the instruction in ID
//   ID_uses_rs2       - instruction in ID reads rs2
//   EX_rd/EX_memread  - destination register and load flag of the EX instruction
//   JumpPC            - taken jump/branch resolved in EX
//   mem_wait          - data memory not ready, whole pipeline holds
//   pc_en, ifid_en    - PC and IF/ID load enables (combinational)
//   ifid_flush        - IF/ID loads a NOP (combinational)
//   idex_flush        - ID/EX loads a bubble (combinational)
//   busy              - controller is flushing or waiting (combinational)
//   err_timeout       - sticky watchdog error (registered)
//   bubble_cnt        - saturating count of inserted bubbles (registered)
module if_id_hazard_ctrl #(
  parameter int unsigned REG_W     = 3,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic             ID_uses_rs2,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_memread,
  input  logic             JumpPC,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             busy,
  output logic             err_timeout,
  output logic [7:0]       bubble_cnt
);

  localparam int unsigned FCNT_W = 3;
  localparam int unsigned WCNT_W = 8;
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYC - 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT   = WCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                err_q, err_d;
  logic [7:0]          bubble_q, bubble_d;
  logic                lu_hazard;
  logic                pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, busy_c;

  // Load in EX feeding a source of the ID instruction; r0 never hazards.
  assign lu_hazard = EX_memread && (EX_rd != '0) &&
                     ((EX_rd == ID_rs1) || (ID_uses_rs2 && (EX_rd == ID_rs2)));

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RUN;
      fcnt_q   <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      bubble_q <= bubble_d;
    end
  end

  // Next-state and output decode; priority mem_wait > JumpPC > lu_hazard.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    bubble_d     = bubble_q;
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    busy_c       = (state_q != S_RUN);

    unique case (state_q)
      S_FLUSH: begin
        if (mem_wait) begin
          // Hold everything, counter frozen.
          pc_en_c   = 1'b0;
          ifid_en_c = 1'b0;
        end else begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          if (JumpPC) begin
            fcnt_d = FLUSH_RELOAD;
          end else if (fcnt_q == FCNT_W'(1)) begin
            state_d = S_RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
      end
      default: begin
        // RUN, and WAIT once mem_wait drops (evaluated as RUN that cycle).
        if (mem_wait) begin
          pc_en_c   = 1'b0;
          ifid_en_c = 1'b0;
          state_d   = S_WAIT;
          if (state_q == S_WAIT)
            wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCNT_W'(1);
          else
            wcnt_d = WCNT_W'(1);
          if (wcnt_d == WAIT_LIMIT)
            err_d = 1'b1;
        end else begin
          state_d = S_RUN;
          wcnt_d  = '0;
          if (JumpPC) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_d = S_FLUSH;
              fcnt_d  = FLUSH_RELOAD;
            end
          end else if (lu_hazard) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
          end
        end
      end
    endcase

    if (idex_flush_c && (bubble_q != 8'hFF))
      bubble_d = bubble_q + 8'd1;
  end

  // Reset forces the idle pipeline controls regardless of inputs.
  assign pc_en       = rst ? pc_en_c      : 1'b1;
  assign ifid_en     = rst ? ifid_en_c    : 1'b1;
  assign ifid_flush  = rst ? ifid_flush_c : 1'b0;
  assign idex_flush  = rst ? idex_flush_c : 1'b0;
  assign busy        = rst ? busy_c       : 1'b0;
  assign err_timeout = err_q;
  assign bubble_cnt  = bubble_q;

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 8-bit in-order pipeline.
- Drives PC enable, IF/ID write-enable and flush, and ID/EX bubble insertion.
- Resolves three hazards: load-use, taken jump (JumpPC) and data-memory wait.
- Also keeps a stall watchdog and a saturating bubble counter for debug.

Parameters:
- REG_W, 3, width of register index fields.
- FLUSH_CYC, 1, number of cycles IF/ID is flushed after a taken jump (1..7).
- TIMEOUT, 16, consecutive mem_wait cycles before err_timeout is set (2..255).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- ID_rs1  input  REG_W  source register 1 of the instruction in ID.
- ID_rs2  input  REG_W  source register 2 of the instruction in ID.
- ID_uses_rs2  input  1  instruction in ID reads rs2.
- EX_rd  input  REG_W  destination register of the instruction in EX.
- EX_memread  input  1  instruction in EX is a load.
- JumpPC  input  1  taken jump/branch resolved in EX this cycle.
- mem_wait  input  1  data memory not ready; the whole pipeline must hold.
- pc_en  output  1  PC register update enable.
- ifid_en  output  1  IF/ID register load enable.
- ifid_flush  output  1  IF/ID loads a NOP (8'h00) instead of IF_instr.
- idex_flush  output  1  ID/EX loads a bubble.
- busy  output  1  FSM is not in RUN.
- err_timeout  output  1  sticky watchdog error.
- bubble_cnt  output  8  saturating count of inserted bubbles.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, flush counter=0, wait counter=0, err_timeout=0, bubble_cnt=0.
  - Outputs during reset: pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0, busy=0.
  - Reset mid-operation aborts any flush or wait immediately.
- lu_hazard is combinational: EX_memread && EX_rd!=0 && (EX_rd==ID_rs1 || (ID_uses_rs2 && EX_rd==ID_rs2)). Register 0 never creates a hazard.
- Outputs are combinational from state and inputs, so the IF/ID and ID/EX registers act at the same rising edge.
- Priority each cycle: mem_wait > JumpPC > lu_hazard.
- State RUN:
  - mem_wait=1: pc_en=0, ifid_en=0, no flushes. Next state WAIT, wait counter=1.
  - else JumpPC=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Next state FLUSH if FLUSH_CYC>1, with flush counter=FLUSH_CYC-1; else stay RUN.
  - else lu_hazard=1: pc_en=0, ifid_en=0, idex_flush=1, for a 1-cycle bubble. Stay RUN; the hazard clears naturally the next cycle.
  - else: all enables 1, no flushes.
- State FLUSH:
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
  - Counter decrements each cycle; at 1 the next state is RUN.
  - mem_wait=1: hold all (pc_en=ifid_en=0, no flush) and freeze the counter.
  - A new JumpPC reloads the counter to FLUSH_CYC-1.
  - lu_hazard is ignored in FLUSH.
- State WAIT:
  - pc_en=0, ifid_en=0, no flushes; wait counter increments (saturates at 255).
  - mem_wait=0: return to RUN. The same cycle is evaluated as RUN (jump/hazard apply).
  - Wait counter reaching TIMEOUT sets err_timeout. It is sticky until reset, and the state still waits.
- busy=1 in FLUSH and WAIT.
- bubble_cnt:
  - +1 on every cycle with idex_flush=1 (RUN jump, RUN load-use, FLUSH without wait).
  - Saturates at 8'hFF, no wrap.
- JumpPC and lu_hazard together: the jump wins; flush both registers with no stall.

Test Plan:
- Reset then idle: rst low 3 cycles, release, no hazards -> pc_en=ifid_en=1, flushes=0, busy=0, bubble_cnt=0.
- Load-use: EX_memread=1, EX_rd=3, ID_rs1=3 for 1 cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; bubble_cnt=1. Repeat with EX_rd=0 -> no stall.
- Jump with FLUSH_CYC=2: JumpPC pulse 1 cycle -> ifid_flush=idex_flush=1 for 2 cycles, busy=1 on the second; bubble_cnt=2. JumpPC together with lu_hazard -> flush with pc_en=1.
- Mem wait: mem_wait=1 for 5 cycles -> pc_en=ifid_en=0 for all 5, busy=1 from cycle 2, err_timeout=0; release -> RUN the same cycle.
- Watchdog with TIMEOUT=16: mem_wait held 20 cycles -> err_timeout rises after the 16th wait cycle and stays 1 after release until rst.
- Saturation and reset mid-op: 300 load-use bubbles -> bubble_cnt=8'hFF. Assert rst during FLUSH -> immediately RUN, bubble_cnt=0.
